// File: rtl/hgcal_in_pkg.sv
// Shared constants, state encoding and sizing helper for the HGCAL input packer.
package hgcal_in_pkg;

    localparam int ACT_BITS = 2;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        DROP = 2'd2
    } state_e;

    // Counter width able to index N slots; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hgcal_quantizer.sv
// Three-comparator threshold unit mapping one unsigned raw sample to a 2-bit activation code.
module hgcal_quantizer
    import hgcal_in_pkg::*;
#(
    parameter int                   IN_WIDTH = 10,
    parameter logic [IN_WIDTH-1:0]  T1       = 10'd64,
    parameter logic [IN_WIDTH-1:0]  T2       = 10'd192,
    parameter logic [IN_WIDTH-1:0]  T3       = 10'd448
) (
    input  logic [IN_WIDTH-1:0] sample,
    output logic [ACT_BITS-1:0] code
);

    // Thresholds are ordered, so the highest one crossed wins.
    always_comb begin
        if (sample >= T3)
            code = 2'd3;
        else if (sample >= T2)
            code = 2'd2;
        else if (sample >= T1)
            code = 2'd1;
        else
            code = 2'd0;
    end

endmodule

// File: rtl/hgcal_input_packer.sv
// Streams raw cell samples in, quantizes them and packs one frame of codes into the
// layer-0 activation vector presented on a registered valid/ready output.
module hgcal_input_packer
    import hgcal_in_pkg::*;
#(
    parameter int                   N_INPUTS = 48,
    parameter int                   IN_WIDTH = 10,
    parameter logic [IN_WIDTH-1:0]  T1       = 10'd64,
    parameter logic [IN_WIDTH-1:0]  T2       = 10'd192,
    parameter logic [IN_WIDTH-1:0]  T3       = 10'd448
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_WIDTH-1:0]          s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [ACT_BITS*N_INPUTS-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         frame_err
);

    localparam int CW    = cnt_width(N_INPUTS);
    localparam int FRAME = ACT_BITS * N_INPUTS;

    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_FULL = FULL;
    localparam logic [1:0] ST_DROP = DROP;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [FRAME-1:0]    acc;
    logic                held_long;

    logic [ACT_BITS-1:0] code;
    logic [FRAME-1:0]    filled;
    logic                accept;
    logic                at_end;
    logic                close;
    logic                close_long;
    logic                close_short;
    logic                out_free;

    hgcal_quantizer #(
        .IN_WIDTH (IN_WIDTH),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3)
    ) u_quant (
        .sample (s_data),
        .code   (code)
    );

    // The held frame blocks intake; reset also keeps the input closed.
    assign s_ready = !rst && (state != ST_FULL);

    // NOTE: every output of this block is assigned first so no path leaves a latch.
    always_comb begin
        filled      = acc;
        filled[int'(cnt)*ACT_BITS +: ACT_BITS] = code;
        accept      = s_valid && s_ready;
        at_end      = (cnt == CW'(N_INPUTS - 1));
        close       = accept && (state == ST_FILL) && (s_last || at_end);
        close_long  = close && at_end && !s_last;
        close_short = close && s_last && !at_end;
        out_free    = !m_valid || m_ready;
    end

    // NOTE: the accumulation and output registers are plain flops and are cleared on
    // reset so a partial or pending frame can never leak out after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FILL;
            cnt       <= '0;
            acc       <= '0;
            held_long <= 1'b0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let later branches override these defaults.
            frame_err <= 1'b0;
            if (m_ready)
                m_valid <= 1'b0;

            case (state)
                ST_FILL: begin
                    if (close) begin
                        cnt       <= '0;
                        frame_err <= close_long || close_short;
                        if (out_free) begin
                            m_data  <= filled;
                            m_valid <= 1'b1;
                            acc     <= '0;
                            state   <= close_long ? ST_DROP : ST_FILL;
                        end else begin
                            acc       <= filled;
                            held_long <= close_long;
                            state     <= ST_FULL;
                        end
                    end else if (accept) begin
                        acc <= filled;
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_FULL: begin
                    if (m_ready) begin
                        m_data  <= acc;
                        m_valid <= 1'b1;
                        acc     <= '0;
                        state   <= held_long ? ST_DROP : ST_FILL;
                    end
                end

                // Overlong tail is swallowed up to and including its s_last.
                ST_DROP: begin
                    if (accept && s_last)
                        state <= ST_FILL;
                end

                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
